multi_pipe_tree: RTL and testbench



---
 rtl/multi_pipe_tree_if.sv | 32 +++
 rtl/multi_pipe_tree.sv | 100 ++++++++++
 tb/tb_multi_pipe_tree.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/multi_pipe_tree_if.sv
// multi_pipe_tree_if
// Purpose: groups the operand/result handshake of multi_pipe_tree.
// Parameter: WIDTH - operand width (must match the multiplier's WIDTH).
// Signals:
//   in_valid, in_ready       - operand-side handshake
//   mode_signed              - two's-complement operands (sampled with the operands)
//   mul_a, mul_b [WIDTH]     - multiplicand / multiplier
//   out_valid, out_ready     - result-side handshake
//   mul_out [2*WIDTH]        - product
// Modports: master = operand source / result sink, slave = multiplier.
interface multi_pipe_tree_if #(
  parameter int WIDTH = 8
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 mode_signed;
  logic [WIDTH-1:0]     mul_a;
  logic [WIDTH-1:0]     mul_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   mul_out;

  modport master (
    output in_valid, mode_signed, mul_a, mul_b, out_ready,
    input  in_ready, out_valid, mul_out
  );

  modport slave (
    input  in_valid, mode_signed, mul_a, mul_b, out_ready,
    output in_ready, out_valid, mul_out
  );
endinterface

// File: rtl/multi_pipe_tree.sv
// multi_pipe_tree
// Purpose: pipelined WIDTH x WIDTH multiplier. Stage 0 registers WIDTH
// partial products, then log2(WIDTH) registered adder-tree stages halve the
// row count until one row (the product) remains. Latency LAT = 1 + log2(WIDTH)
// cycles, one operation per cycle, global stall on output backpressure.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   bus    - multi_pipe_tree_if.slave (operands, handshakes, product)
// Configuration macro: MULTI_PIPE_SIGNED_EN
//   defined   - mode_signed selects two's-complement multiply per operation
//   undefined - mode_signed ignored, unsigned multiply only
module multi_pipe_tree #(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  multi_pipe_tree_if.slave bus
);

  localparam int LOG2W = $clog2(WIDTH);
  localparam int LAT   = 1 + LOG2W;
  localparam int W2    = 2 * WIDTH;
  // Whole tree stored flat: rows 0..WIDTH-1 are the partial products, the
  // following entries are the sums of each later stage in order, and the
  // last entry is the final product. With this layout node k (k >= WIDTH)
  // is the sum of nodes 2*(k-WIDTH) and 2*(k-WIDTH)+1.
  localparam int NODES = 2 * WIDTH - 1;

  logic [W2-1:0]  node_r [NODES];
  logic [LAT-1:0] valid_r;
  logic [W2-1:0]  pp_s [WIDTH];
  logic [W2-1:0]  ext_a_s;
  logic [W2-1:0]  top_row_s;
  logic           stall_s;

`ifdef MULTI_PIPE_SIGNED_EN
  logic           signed_s;
  assign signed_s = bus.mode_signed;
`else
  logic           unused_mode_s;
  assign unused_mode_s = bus.mode_signed;
`endif

  // Whole pipeline freezes while a finished result waits for the consumer.
  assign stall_s       = valid_r[LAT-1] & ~bus.out_ready;
  assign bus.in_ready  = ~stall_s;
  assign bus.out_valid = valid_r[LAT-1];
  assign bus.mul_out   = node_r[NODES-1];

  // Partial-product generation for stage 0.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp_s[i] = {W2{1'b0}};
    end
`ifdef MULTI_PIPE_SIGNED_EN
    ext_a_s = signed_s ? {{WIDTH{bus.mul_a[WIDTH-1]}}, bus.mul_a}
                       : {{WIDTH{1'b0}}, bus.mul_a};
`else
    ext_a_s = {{WIDTH{1'b0}}, bus.mul_a};
`endif
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (bus.mul_b[i]) begin
        pp_s[i] = ext_a_s << i;
      end else begin
        pp_s[i] = {W2{1'b0}};
      end
    end
    if (bus.mul_b[WIDTH-1]) begin
      top_row_s = ext_a_s << (WIDTH - 1);
    end else begin
      top_row_s = {W2{1'b0}};
    end
`ifdef MULTI_PIPE_SIGNED_EN
    // The multiplier's MSB carries weight -2^(WIDTH-1) in signed mode.
    pp_s[WIDTH-1] = signed_s ? ({W2{1'b0}} - top_row_s) : top_row_s;
`else
    pp_s[WIDTH-1] = top_row_s;
`endif
  end

  // Stage registers and travelling valid bits; everything holds on stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NODES; k++) begin
        node_r[k] <= {W2{1'b0}};
      end
      valid_r <= {LAT{1'b0}};
    end else if (!stall_s) begin
      for (int i = 0; i < WIDTH; i++) begin
        node_r[i] <= pp_s[i];
      end
      for (int k = WIDTH; k < NODES; k++) begin
        node_r[k] <= node_r[2*(k-WIDTH)] + node_r[2*(k-WIDTH)+1];
      end
      valid_r <= {valid_r[LAT-2:0], bus.in_valid};
    end
  end

endmodule

// File: tb/tb_multi_pipe_tree.sv
// tb_multi_pipe_tree
// Purpose: self-checking bench for multi_pipe_tree. A WIDTH=8 instance is
// checked every cycle against a reference model that keeps the expected
// products in order together with the cycles each still needs before it is
// due; a WIDTH=4 instance gets directed latency/value checks.
// Honours MULTI_PIPE_SIGNED_EN the same way the design does.
module tb_multi_pipe_tree;

  localparam int LAT8 = 4;
`ifdef MULTI_PIPE_SIGNED_EN
  localparam logic [7:0] W4_SIGNED_EXP = 8'h01;
  localparam logic       SIGNED_ON     = 1'b1;
`else
  localparam logic [7:0] W4_SIGNED_EXP = 8'hE1;
  localparam logic       SIGNED_ON     = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  multi_pipe_tree_if #(.WIDTH(8)) bus8 ();
  multi_pipe_tree_if #(.WIDTH(4)) bus4 ();

  multi_pipe_tree #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  multi_pipe_tree #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // expected products in issue order, and cycles left until each is due
  logic [15:0] prod_q [$];
  int          due_q  [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ref_prod(input logic sg, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] xa;
    logic [15:0] xb;
    xa = {8'h00, a};
    xb = {8'h00, b};
    if (sg) begin
      xa = {{8{a[7]}}, a};
      xb = {{8{b[7]}}, b};
    end
    return xa * xb;
  endfunction

  // One clock cycle on the WIDTH=8 instance: drive, check, clock, update model.
  task automatic cyc(input logic v, input logic sg, input logic [7:0] a,
                     input logic [7:0] b, input logic ordy, input string tag);
    logic exp_ov;
    logic stall;
    bus8.in_valid    = v;
    bus8.mode_signed = sg;
    bus8.mul_a       = a;
    bus8.mul_b       = b;
    bus8.out_ready   = ordy;
    #1;
    exp_ov = (prod_q.size() > 0) && (due_q[0] == 0);
    stall  = exp_ov && !ordy;
    check({tag, ":in_ready"}, 32'(bus8.in_ready), 32'(!stall));
    check({tag, ":out_valid"}, 32'(bus8.out_valid), 32'(exp_ov));
    if (exp_ov) begin
      check({tag, ":mul_out"}, 32'(bus8.mul_out), 32'(prod_q[0]));
    end
    @(posedge clk);
    if (!stall) begin
      if (exp_ov) begin
        void'(prod_q.pop_front());
        void'(due_q.pop_front());
      end
      foreach (due_q[i]) begin
        if (due_q[i] > 0) due_q[i] = due_q[i] - 1;
      end
      if (v) begin
        prod_q.push_back(ref_prod(sg & SIGNED_ON, a, b));
        due_q.push_back(LAT8 - 1);
      end
    end
    #1;
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, tag);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    bus8.in_valid = 1'b0; bus8.mode_signed = 1'b0; bus8.mul_a = 8'h00;
    bus8.mul_b = 8'h00; bus8.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.mode_signed = 1'b0; bus4.mul_a = 4'h0;
    bus4.mul_b = 4'h0; bus4.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // reset state
    check("rst8:out_valid", 32'(bus8.out_valid), 32'(1'b0));
    check("rst8:mul_out", 32'(bus8.mul_out), 32'(16'h0000));
    check("rst8:in_ready", 32'(bus8.in_ready), 32'(1'b1));
    check("rst4:out_valid", 32'(bus4.out_valid), 32'(1'b0));
    check("rst4:mul_out", 32'(bus4.mul_out), 32'(8'h00));
    rst_n = 1'b1;

    // WIDTH=4: 0xF x 0xF unsigned, result after exactly 3 cycles
    bus4.in_valid = 1'b1; bus4.mode_signed = 1'b0; bus4.mul_a = 4'hF; bus4.mul_b = 4'hF;
    idle(1, "w4u0");
    bus4.in_valid = 1'b0;
    check("w4u:ov_c1", 32'(bus4.out_valid), 32'(1'b0));
    idle(1, "w4u1");
    check("w4u:ov_c2", 32'(bus4.out_valid), 32'(1'b0));
    idle(1, "w4u2");
    check("w4u:ov_c3", 32'(bus4.out_valid), 32'(1'b1));
    check("w4u:mul_out", 32'(bus4.mul_out), 32'(8'hE1));
    idle(1, "w4u3");
    check("w4u:ov_after", 32'(bus4.out_valid), 32'(1'b0));

    // WIDTH=4: mode_signed=1 with 0xF x 0xF
    bus4.in_valid = 1'b1; bus4.mode_signed = 1'b1;
    idle(1, "w4s0");
    bus4.in_valid = 1'b0; bus4.mode_signed = 1'b0;
    idle(2, "w4s1");
    check("w4s:ov_c3", 32'(bus4.out_valid), 32'(1'b1));
    check("w4s:mul_out", 32'(bus4.mul_out), 32'(W4_SIGNED_EXP));

    // WIDTH=8: 0xFF x 0xFF unsigned, timing from the model
    cyc(1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, "ff");
    idle(LAT8 + 1, "ff_drain");

    // signed / unsigned interleave, back-to-back
    cyc(1'b1, 1'b1, 8'h80, 8'h80, 1'b1, "s8080");
    cyc(1'b1, 1'b0, 8'h80, 8'h80, 1'b1, "u8080");
    cyc(1'b1, 1'b1, 8'hFF, 8'h01, 1'b1, "sff01");
    cyc(1'b1, 1'b1, 8'h7F, 8'h81, 1'b1, "s7f81");
    idle(LAT8 + 1, "mix_drain");

    // zero operands in both modes
    cyc(1'b1, 1'b1, 8'h00, 8'hA7, 1'b1, "zero_s");
    cyc(1'b1, 1'b0, 8'hC3, 8'h00, 1'b1, "zero_u");
    idle(LAT8 + 1, "zero_drain");

    // streaming: 16 random operations back-to-back
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 1'($urandom_range(1)), 8'($urandom), 8'($urandom), 1'b1, "stream");
    end
    idle(LAT8 + 1, "stream_drain");
    check("stream:empty", 32'(prod_q.size()), 32'(0));

    // backpressure: 6 ops, 3 stalled cycles (one offers an op that must not be taken)
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 1'($urandom_range(1)), 8'($urandom), 8'($urandom), 1'b1, "bp_issue");
    end
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "bp_stall");
    cyc(1'b1, 1'b0, 8'h55, 8'h33, 1'b0, "bp_stall");
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, "bp_stall");
    idle(LAT8 + 6, "bp_drain");
    check("bp:empty", 32'(prod_q.size()), 32'(0));

    // reset with results emerging and operations in flight
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 8'hC0 + 8'(i), 8'hA5, 1'b1, "rst_fill");
    end
    rst_n = 1'b0;
    bus8.in_valid = 1'b0;
    #1;
    check("midrst:out_valid", 32'(bus8.out_valid), 32'(1'b0));
    check("midrst:mul_out", 32'(bus8.mul_out), 32'(16'h0000));
    check("midrst:in_ready", 32'(bus8.in_ready), 32'(1'b1));
    prod_q.delete();
    due_q.delete();
    @(posedge clk);
    #1;
    check("midrst:held", 32'(bus8.out_valid), 32'(1'b0));
    rst_n = 1'b1;
    cyc(1'b1, 1'b0, 8'h12, 8'h13, 1'b1, "post_rst");
    idle(LAT8 + 3, "post_rst_drain");
    check("post_rst:empty", 32'(prod_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
